uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter BAUD_RATE, default 9_600, serial bit rate in bits/s.
REQ-002 Parameter SYS_CLK_FREQ, default 48_000_000, clk frequency in Hz.
REQ-003 Port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port data_in  input  8  byte to transmit; sampled only on an accepting edge.
REQ-006 Port data_valid  input  1  data_in holds a byte offered for transmission.
REQ-007 Port data_ready  output  1  holding register empty; a byte can be accepted.
REQ-008 Port tx  output  1  UART TX line; high when idle.
REQ-009 Port busy  output  1  high while a frame is in flight or the holding register is full.
REQ-010 Port tx_done  output  1  one-cycle pulse marking the last cycle of each stop bit.

Function
REQ-011 BIT_PERIOD SHALL be SYS_CLK_FREQ / BAUD_RATE (integer division), with BIT_PERIOD >= 2; the bit timer SHALL be wide enough to hold BIT_PERIOD-1.
REQ-012 Frame format SHALL be: one start bit (0), 8 data bits LSB first, optional parity bit (REQ-026), and one stop bit (1).
REQ-013 Every frame bit SHALL drive tx for exactly BIT_PERIOD clk cycles.
REQ-014 A byte SHALL be accepted into the one-entry holding register on any edge where data_valid && data_ready; data_ready SHALL deassert on the following cycle.
REQ-015 When data_valid is high and data_ready is low, nothing SHALL be accepted; the source holds data_in stable.
REQ-016 FSM states: IDLE, SEND_START_BIT, SEND_DATA_BITS, SEND_PARITY_BIT (present only with the macro), SEND_STOP_BIT.
REQ-017 In IDLE with the holding register full, the FSM SHALL copy the holding register to the shift register, empty the holding register, and enter SEND_START_BIT on the same edge.
REQ-018 Latency: for a byte accepted at edge E while the transmitter is IDLE and empty, tx SHALL go low at edge E+1.
REQ-019 SEND_DATA_BITS SHALL track bit_index 0..7; after bit 7 has run for BIT_PERIOD cycles, the FSM SHALL go to SEND_PARITY_BIT if compiled in, otherwise to SEND_STOP_BIT.
REQ-020 At the end of the stop bit, if the holding register is full the FSM SHALL load it and enter SEND_START_BIT directly, with zero idle cycles between frames; otherwise it SHALL return to IDLE.
REQ-021 An acceptance and a holding-to-shifter transfer on the same edge: the transfer SHALL take the old holding value and the holding register SHALL end full with the new byte.
REQ-022 tx_done SHALL be high for exactly one cycle per frame, the final cycle of the stop bit; busy SHALL equal (state != IDLE) || holding register full.
REQ-023 An undefined state encoding SHALL return the FSM to IDLE with tx high.

Reset
REQ-024 While reset is high, asynchronously: state=IDLE, tx=1, data_ready=1, busy=0, tx_done=0, timer=0, bit_index=0, shift and holding registers=0.
REQ-025 Reset mid-frame SHALL abandon the frame, including any held byte; no tx_done SHALL be emitted for it, and operation SHALL resume normally on the first edge after reset deasserts.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: an even-parity bit (XOR of the 8 data bits) SHALL be sent after bit 7, giving an 11-bit frame of 11*BIT_PERIOD cycles.
REQ-027 Macro UART_TX_PARITY_EN undefined: no parity state or logic SHALL exist, giving a 10-bit frame of 10*BIT_PERIOD cycles.

Verification (SYS_CLK_FREQ=1_000_000, BAUD_RATE=100_000, BIT_PERIOD=10)
REQ-028 Send 0x55 with no parity -> tx reads 0,1,0,1,0,1,0,1,0,1, each bit for 10 cycles, with tx low at E+1; tx_done pulses at cycle E+100; tx then stays high.
REQ-029 Send 0xA5, then offer 0x3C during its data bits -> 0x3C is accepted while 0xA5 is in flight; its start bit immediately follows the 0xA5 stop bit; two tx_done pulses 100 cycles apart; busy stays high for 200 cycles.
REQ-030 With UART_TX_PARITY_EN defined, send 0x07 then 0x03 -> parity bits are 1 and 0; frames are 110 cycles each.
REQ-031 Assert reset during data bit 3 of 0xF0 -> tx=1 and data_ready=1 without waiting for a clk edge; no tx_done; a following 0x81 transmits correctly.
REQ-032 Hold data_valid=1 with changing data_in while data_ready=0 -> only bytes present on accepting edges appear on tx, in order.

Source files
------------

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - UART transmitter with a one-entry holding register
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7.
module uart_transmitter #(
  parameter int BAUD_RATE    = 9_600,
  parameter int SYS_CLK_FREQ = 48_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int BIT_PERIOD = SYS_CLK_FREQ / BAUD_RATE;
  localparam int TW = $clog2(BIT_PERIOD);
  localparam logic [TW-1:0] BIT_LAST = TW'(BIT_PERIOD - 1);

  localparam logic [2:0] IDLE           = 3'd0;
  localparam logic [2:0] SEND_START_BIT = 3'd1;
  localparam logic [2:0] SEND_DATA_BITS = 3'd2;
  localparam logic [2:0] SEND_STOP_BIT  = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] SEND_PARITY_BIT = 3'd4;
`endif

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          bit_end;
  logic          load;
  logic          accept;

  assign bit_end    = (timer_q == BIT_LAST);
  assign data_ready = ~hold_full_q;
  assign accept     = data_valid & ~hold_full_q;
  assign busy       = (state_q != IDLE) | hold_full_q;
  assign tx_done    = (state_q == SEND_STOP_BIT) & bit_end;

  always_comb begin
    tx = 1'b1;
    case (state_q)
      SEND_START_BIT:  tx = 1'b0;
      SEND_DATA_BITS:  tx = shift_q[bit_idx_q];
`ifdef UART_TX_PARITY_EN
      SEND_PARITY_BIT: tx = ^shift_q;
`endif
      SEND_STOP_BIT:   tx = 1'b1;
      default:         tx = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d   = '0;
        bit_idx_d = '0;
        load      = hold_full_q;
      end
      SEND_START_BIT: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        if (bit_end) begin
          state_d   = SEND_DATA_BITS;
          bit_idx_d = '0;
        end
      end
      SEND_DATA_BITS: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = SEND_PARITY_BIT;
`else
            state_d = SEND_STOP_BIT;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      SEND_PARITY_BIT: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        if (bit_end) state_d = SEND_STOP_BIT;
      end
`endif
      SEND_STOP_BIT: begin
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        if (bit_end) begin
          if (hold_full_q) load = 1'b1;
          else state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        timer_d   = '0;
        bit_idx_d = '0;
      end
    endcase

    // Transfer always takes the old holding value; a same-edge accept refills it.
    if (load) begin
      shift_d     = hold_q;
      state_d     = SEND_START_BIT;
      timer_d     = '0;
      bit_idx_d   = '0;
      hold_d      = '0;
      hold_full_d = 1'b0;
    end
    if (accept) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - self-checking bench for uart_transmitter (BIT_PERIOD = 10)
module tb_uart_transmitter;

  localparam int BP = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       tx;
  logic       busy;
  logic       tx_done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  uart_transmitter #(.BAUD_RATE(100_000), .SYS_CLK_FREQ(1_000_000)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: frame offset counter (-1 = no frame) plus a one-slot buffer.
  int         m_off  = -1;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_hold = 8'h00;
  logic       m_full = 1'b0;
  logic       m_was_full;
  logic [7:0] m_old_hold;

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NB == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_off  = -1;
      m_full = 1'b0;
      m_hold = 8'h00;
    end else begin
      m_was_full = m_full;
      m_old_hold = m_hold;
      if (m_off >= 0) m_off = (m_off == NB*BP-1) ? -1 : m_off + 1;
      if (m_off < 0 && m_was_full) begin
        m_off  = 0;
        m_byte = m_old_hold;
        m_full = 1'b0;
      end
      if (data_valid && !m_was_full) begin
        m_full = 1'b1;
        m_hold = data_in;
      end
    end
  end

  logic etx;
  always @(negedge clk) begin
    etx = (m_off < 0) ? 1'b1 : frame_bit(m_byte, m_off / BP);
    chk("tx", tx, etx);
    chk("data_ready", data_ready, !m_full);
    chk("busy", busy, (m_off >= 0) || m_full);
    chk("tx_done", tx_done, m_off == NB*BP-1);
  end

  task automatic wait_idle();
    int n = 0;
    while (!(m_off < 0 && !m_full) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_frame(input logic [7:0] b, input logic par);
    logic ebit;
    int   k;
    wait_idle();
    data_in = b; data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    for (int c = 1; c <= NB*BP; c++) begin
      @(posedge clk); #2;
      if (c == 1) chk("latency_start", tx, 1'b0);
      if ((c-1) % BP == 5) begin
        k = (c-1) / BP;
        if (k == 0) ebit = 1'b0;
        else if (k <= 8) ebit = b[k-1];
        else if (NB == 11 && k == 9) ebit = par;
        else ebit = 1'b1;
        chk($sformatf("frame_%02h_bit%0d", b, k), tx, ebit);
      end
      if (c == NB*BP-1) chk("done_early", tx_done, 1'b0);
      if (c == NB*BP) chk("done_at_end", tx_done, 1'b1);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t tbl[10];

  int d1, d2, busy_low;

  initial begin
    tbl[0] = '{8'h55, 1'b0};
    tbl[1] = '{8'hA5, 1'b0};
    tbl[2] = '{8'h07, 1'b1};
    tbl[3] = '{8'h03, 1'b0};
    tbl[4] = '{8'hFF, 1'b0};
    tbl[5] = '{8'h00, 1'b0};
    tbl[6] = '{8'h80, 1'b1};
    tbl[7] = '{8'hF0, 1'b0};
    tbl[8] = '{8'hC8, 1'b1};
    tbl[9] = '{8'h3C, 1'b0};

    reset = 1'b1; data_valid = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", data_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) check_frame(tbl[i].data, tbl[i].par);

    // Back-to-back: second byte offered during the first frame's data bits.
    wait_idle();
    data_in = 8'hA5; data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    chk("b2b_ready_inflight", data_ready, 1'b1);
    data_in = 8'h3C; data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    chk("b2b_held", data_ready, 1'b0);
    d1 = -1; d2 = -1; busy_low = 0;
    for (int i = 0; i < 400 && d2 < 0; i++) begin
      @(posedge clk); #2;
      if (d1 >= 0 && cyc == d1 + 1) chk("b2b_start_follows", tx, 1'b0);
      if (!busy) busy_low++;
      if (tx_done) begin
        if (d1 < 0) d1 = cyc;
        else d2 = cyc;
      end
    end
    chk("b2b_done_gap", d2 - d1, NB*BP);
    chk("b2b_busy_held", busy_low, 0);

    // Reset during data bit 3 of 0xF0.
    wait_idle();
    data_in = 8'hF0; data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (45) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_tx", tx, 1'b1);
    chk("midrst_ready", data_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", tx_done, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_frame(8'h81, 1'b0);

    // data_valid held high with data_in changing every cycle.
    wait_idle();
    data_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      data_in = 8'($urandom);
      @(posedge clk); #1;
    end
    data_valid = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      data_valid = ($urandom_range(0, 3) != 0);
      data_in = 8'($urandom);
      @(posedge clk); #1;
    end
    data_valid = 1'b0;
    wait_idle();
    repeat (5) @(posedge clk);
    #2;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
